// File: rtl/cp_apb_master_if.sv
// Host command/response channel and APB initiator bus of cp_apb_master.
// The master modport is the initiator's view; slave is the host/APB-target view.
interface cp_apb_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              iCmdValid;
    logic              oCmdReady;
    logic              iCmdWrite;
    logic [ADDR_W-1:0] iCmdAddr;
    logic [DATA_W-1:0] iCmdWdata;
    logic              oRspValid;
    logic              iRspReady;
    logic [DATA_W-1:0] oRspRdata;
    logic              oBusy;
    logic              oPsel;
    logic              oPenable;
    logic              oPwrite;
    logic [ADDR_W-1:0] oPaddr;
    logic [DATA_W-1:0] oPwdata;
    logic [DATA_W-1:0] iPrdata;

    modport master (
        input  iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iRspReady, iPrdata,
        output oCmdReady, oRspValid, oRspRdata, oBusy,
        output oPsel, oPenable, oPwrite, oPaddr, oPwdata
    );

    modport slave (
        output iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iRspReady, iPrdata,
        input  oCmdReady, oRspValid, oRspRdata, oBusy,
        input  oPsel, oPenable, oPwrite, oPaddr, oPwdata
    );
endinterface

// File: rtl/cp_apb_master.sv
// APB initiator: in-order command queue, fixed SETUP/ACCESS transfers, one-entry read response slot.
// Define CP_APB_BACK2BACK_EN to chain ACCESS directly into the next SETUP (2 cycles per transfer).
module cp_apb_master #(
    parameter int CMD_DEPTH = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32
) (
    input  logic             iClk,
    input  logic             iRsn,
    cp_apb_master_if.master  bus
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    logic              r_q_write [CMD_DEPTH];
    logic [ADDR_W-1:0] r_q_addr  [CMD_DEPTH];
    logic [DATA_W-1:0] r_q_wdata [CMD_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_head_write;
    logic              w_head_ok;

    assign w_push       = bus.iCmdValid & r_cmd_ready;
    assign w_pop        = (r_state == S_ACCESS);
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head_write = r_q_write[r_rd_ptr];
    // A read may only start when its data has somewhere to land.
    assign w_head_ok    = (r_count != '0) & (w_head_write | ~r_rsp_valid);

`ifdef CP_APB_BACK2BACK_EN
    logic [PTR_W-1:0] w_nxt_ptr;
    logic             w_nxt_write;
    logic             w_rsp_full_nxt;
    logic             w_nxt_ok;

    assign w_nxt_ptr      = r_rd_ptr + 1'b1;
    assign w_nxt_write    = r_q_write[w_nxt_ptr];
    assign w_rsp_full_nxt = ~r_pwrite | (r_rsp_valid & ~bus.iRspReady);
    assign w_nxt_ok       = (r_count > CNT_W'(1)) & (w_nxt_write | ~w_rsp_full_nxt);
`endif

    // NOTE: queue storage has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_q_write[r_wr_ptr] <= bus.iCmdWrite;
            r_q_addr[r_wr_ptr]  <= bus.iCmdAddr;
            r_q_wdata[r_wr_ptr] <= bus.iCmdWdata;
        end
    end

    // NOTE: all state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt < CNT_W'(CMD_DEPTH));
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_head_ok) begin
                        r_state   <= S_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= w_head_write;
                        r_paddr   <= r_q_addr[r_rd_ptr];
                        r_pwdata  <= w_head_write ? r_q_wdata[r_rd_ptr] : '0;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
`ifdef CP_APB_BACK2BACK_EN
                    if (w_nxt_ok) begin
                        r_state   <= S_SETUP;
                        r_penable <= 1'b0;
                        r_pwrite  <= w_nxt_write;
                        r_paddr   <= r_q_addr[w_nxt_ptr];
                        r_pwdata  <= w_nxt_write ? r_q_wdata[w_nxt_ptr] : '0;
                    end else begin
                        r_state   <= S_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
`else
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
`endif
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    // Capture has priority over consume; read gating keeps them from colliding.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (r_state == S_ACCESS && !r_pwrite) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.iPrdata;
        end else if (bus.iRspReady) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.oCmdReady = r_cmd_ready;
    assign bus.oRspValid = r_rsp_valid;
    assign bus.oRspRdata = r_rsp_rdata;
    assign bus.oBusy     = (r_count != '0) | (r_state != S_IDLE);
    assign bus.oPsel     = r_psel;
    assign bus.oPenable  = r_penable;
    assign bus.oPwrite   = r_pwrite;
    assign bus.oPaddr    = r_paddr;
    assign bus.oPwdata   = r_pwdata;
endmodule

// File: tb/tb_cp_apb_master.sv
// Scoreboard bench for cp_apb_master: directed commands push expected APB transfers and
// read responses into queues; a forked monitor pops and compares as the DUT presents them.
module tb_cp_apb_master;
    localparam int CMD_DEPTH = 4;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cp_apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cp_apb_master #(.CMD_DEPTH(CMD_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .iClk (clk),
        .iRsn (rst_n),
        .bus  (bus)
    );

    // APB target: fixed data for 0x0010, address-tagged data elsewhere, junk outside ACCESS.
    assign bus.iPrdata = (bus.oPsel && bus.oPenable)
                       ? ((bus.oPaddr == 16'h0010) ? 32'hDEAD_BEEF : {16'hC0DE, bus.oPaddr})
                       : 32'h0BAD_0BAD;

    int                n_vec = 0;
    int                n_err = 0;
    xfer_t             exp_x[$];
    logic [DATA_W-1:0] exp_r[$];

    int                cyc = 0;
    logic [127:0]      hist = '0;
    bit                prev_setup = 1'b0;
    xfer_t             setup_x;
    bit                prev_valid = 1'b0;
    bit                prev_cons  = 1'b0;
    logic [DATA_W-1:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd_exp);
        bit    ok;
        xfer_t x;
        ok            = 1'b0;
        bus.iCmdValid = 1'b1;
        bus.iCmdWrite = w;
        bus.iCmdAddr  = a;
        bus.iCmdWdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.oCmdReady;
            tick();
        end
        bus.iCmdValid = 1'b0;
        check("push_accepted", ok, 1);
        if (ok) begin
            x.wr    = w;
            x.addr  = a;
            x.wdata = w ? d : '0;
            exp_x.push_back(x);
            if (!w) exp_r.push_back(rd_exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && bus.oBusy; i++) tick();
        check("drain_timeout_busy", bus.oBusy, 0);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 50 && !bus.oRspValid; i++) tick();
        check("rsp_wait_timeout", bus.oRspValid, 1);
    endtask

    initial begin
        int          t0, n, total, run, max_run, rises, last_rise;
        logic        p, pp;
        bit          seen;

        bus.iCmdValid = 1'b0;
        bus.iCmdWrite = 1'b0;
        bus.iCmdAddr  = '0;
        bus.iCmdWdata = '0;
        bus.iRspReady = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                hist = {hist[126:0], bus.oPsel};
                if (!rst_n) begin
                    prev_setup = 1'b0;
                    prev_valid = 1'b0;
                    prev_cons  = 1'b0;
                end else begin
                    if (bus.oPsel && !bus.oPenable) begin
                        prev_setup    = 1'b1;
                        setup_x.wr    = bus.oPwrite;
                        setup_x.addr  = bus.oPaddr;
                        setup_x.wdata = bus.oPwdata;
                    end else if (bus.oPsel && bus.oPenable) begin
                        check("setup_before_access", prev_setup, 1);
                        check("xfer_expected", exp_x.size() != 0, 1);
                        if (exp_x.size() != 0) begin
                            xfer_t e;
                            e = exp_x.pop_front();
                            check("pwrite", bus.oPwrite, e.wr);
                            check("paddr", bus.oPaddr, e.addr);
                            check("pwdata", bus.oPwdata, e.wdata);
                            check("paddr_stable", bus.oPaddr, setup_x.addr);
                            check("pwdata_stable", bus.oPwdata, setup_x.wdata);
                        end
                        prev_setup = 1'b0;
                    end else begin
                        prev_setup = 1'b0;
                    end

                    if (bus.oRspValid && (!prev_valid || prev_cons)) begin
                        check("rsp_expected", exp_r.size() != 0, 1);
                        if (exp_r.size() != 0) check("rsp_rdata", bus.oRspRdata, exp_r.pop_front());
                    end else if (bus.oRspValid) begin
                        check("rsp_rdata_held", bus.oRspRdata, last_rdata);
                    end
                    prev_valid = bus.oRspValid;
                    prev_cons  = bus.oRspValid && bus.iRspReady;
                    last_rdata = bus.oRspRdata;
                end
            end
        join_none

        // Reset state
        #2;
        check("rst_psel", bus.oPsel, 0);
        check("rst_penable", bus.oPenable, 0);
        check("rst_rspvalid", bus.oRspValid, 0);
        check("rst_busy", bus.oBusy, 0);
        check("rst_cmdready", bus.oCmdReady, 0);
        check("rst_paddr", bus.oPaddr, 0);
        #10 rst_n = 1'b1;
        tick();
        check("post_rst_cmdready", bus.oCmdReady, 1);
        check("post_rst_busy", bus.oBusy, 0);

        // 1: single write, exact SETUP/ACCESS timing
        push(1'b1, 16'h0010, 32'hA5A5_0001, '0);
        check("t1_e0_psel", bus.oPsel, 0);
        check("t1_e0_busy", bus.oBusy, 1);
        tick();
        check("t1_e1_psel", bus.oPsel, 1);
        check("t1_e1_penable", bus.oPenable, 0);
        tick();
        check("t1_e2_psel", bus.oPsel, 1);
        check("t1_e2_penable", bus.oPenable, 1);
        tick();
        check("t1_e3_psel", bus.oPsel, 0);
        check("t1_e3_rspvalid", bus.oRspValid, 0);
        check("t1_e3_busy", bus.oBusy, 0);

        // 2: read returns DEADBEEF, held until consumed
        push(1'b0, 16'h0010, '0, 32'hDEAD_BEEF);
        tick();
        tick();
        check("t2_e2_rspvalid", bus.oRspValid, 0);
        tick();
        check("t2_e3_rspvalid", bus.oRspValid, 1);
        check("t2_e3_rdata", bus.oRspRdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) tick();
        check("t2_hold_rspvalid", bus.oRspValid, 1);
        bus.iRspReady = 1'b1;
        tick();
        bus.iRspReady = 1'b0;
        check("t2_consumed", bus.oRspValid, 0);
        wait_idle();

        // 3: fill the queue behind a blocked read, reject a 5th push, drain in order
        push(1'b0, 16'h0020, '0, 32'hC0DE_0020);
        wait_rsp();
        push(1'b0, 16'h0030, '0, 32'hC0DE_0030);
        push(1'b1, 16'h0040, 32'h1111_4040, '0);
        push(1'b0, 16'h0050, '0, 32'hC0DE_0050);
        check("t3_ready_before_full", bus.oCmdReady, 1);
        push(1'b1, 16'h0060, 32'h2222_6060, '0);
        check("t3_full_ready", bus.oCmdReady, 0);
        bus.iCmdValid = 1'b1;
        bus.iCmdWrite = 1'b1;
        bus.iCmdAddr  = 16'h0070;
        bus.iCmdWdata = 32'h3333_7070;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_full_ready_hold", bus.oCmdReady, 0);
            check("t3_blocked_psel", bus.oPsel, 0);
            check("t3_blocked_busy", bus.oBusy, 1);
        end
        bus.iCmdValid = 1'b0;
        bus.iRspReady = 1'b1;
        wait_idle();
        tick();
        bus.iRspReady = 1'b0;
        check("t3_rspvalid_after", bus.oRspValid, 0);

        // 4: three queued writes, psel shape
        t0 = cyc;
        push(1'b1, 16'h0100, 32'h0000_0100, '0);
        push(1'b1, 16'h0101, 32'h0000_0101, '0);
        push(1'b1, 16'h0102, 32'h0000_0102, '0);
        wait_idle();
        tick();
        n = cyc - t0;
        if (n > 120) n = 120;
        total = 0; run = 0; max_run = 0; rises = 0; last_rise = -1; pp = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            p = hist[i];
            if (p) begin
                total++;
                run++;
                if (run > max_run) max_run = run;
                if (!pp) begin
                    rises++;
                    if (last_rise >= 0) check("t4_rise_spacing", last_rise - i,
`ifdef CP_APB_BACK2BACK_EN
                                              2);
`else
                                              3);
`endif
                    last_rise = i;
                end
            end else begin
                run = 0;
            end
            pp = p;
        end
        check("t4_psel_cycles", total, 6);
`ifdef CP_APB_BACK2BACK_EN
        check("t4_max_run", max_run, 6);
        check("t4_rises", rises, 1);
`else
        check("t4_max_run", max_run, 2);
        check("t4_rises", rises, 3);
`endif

        // 5: second read gated by a full response slot
        push(1'b0, 16'h0200, '0, 32'hC0DE_0200);
        push(1'b0, 16'h0201, '0, 32'hC0DE_0201);
        wait_rsp();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_gated_psel", bus.oPsel, 0);
            check("t5_gated_busy", bus.oBusy, 1);
        end
        bus.iRspReady = 1'b1;
        tick();
        bus.iRspReady = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = bus.oPsel;
        end
        check("t5_rd2_issued", seen, 1);
        wait_rsp();
        bus.iRspReady = 1'b1;
        tick();
        bus.iRspReady = 1'b0;
        wait_idle();

        // 6: async reset in ACCESS with a full response slot and a pending command
        push(1'b0, 16'h0310, '0, 32'hC0DE_0310);
        wait_rsp();
        push(1'b1, 16'h0300, 32'h3333_0300, '0);
        push(1'b1, 16'h0301, 32'h3333_0301, '0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = bus.oPsel && bus.oPenable;
            if (!seen) tick();
        end
        check("t6_reach_access", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_psel", bus.oPsel, 0);
        check("t6_rst_penable", bus.oPenable, 0);
        check("t6_rst_rspvalid", bus.oRspValid, 0);
        exp_x.delete();
        exp_r.delete();
        #5 rst_n = 1'b1;
        tick();
        check("t6_post_busy", bus.oBusy, 0);
        check("t6_post_cmdready", bus.oCmdReady, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_issue_psel", bus.oPsel, 0);
        end

        check("exp_xfer_left", exp_x.size(), 0);
        check("exp_rsp_left", exp_r.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
